// File: rtl/nios_system_nios2_gen2_0_cpu_oci_trace_monitor.sv
// Trace-frame capture monitor: FWFT FIFO of trace frames with a saturating event
// total, a sticky overflow flag, and a capture/drain/done sequencer for end of test.
module nios_system_nios2_gen2_0_cpu_oci_trace_monitor #(
  parameter  int DATA_W = 30,
  parameter  int CNT_W  = 4,
  parameter  int DEPTH  = 16,
  parameter  int TOT_W  = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              dct_valid,
  input  logic              test_ending,
  input  logic              test_has_ended,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [AW:0]       fifo_level,
  output logic              overflow,
  output logic [TOT_W-1:0]  total_count,
  output logic              drain_done
);

  localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;

  typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic               done_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               pop, push_req, push, full;
  logic [SUM_W-1:0]   sum;

  assign rd_valid    = (level_q != '0);
  assign rd_data     = mem_q[rd_ptr_q];
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign total_count = total_q;
  assign drain_done  = done_q;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign push_req = (state_q == CAPTURE) && dct_valid && (dct_count != '0);
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign sum      = SUM_W'(total_q) + SUM_W'(dct_count);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    total_d    = total_q;
    state_d    = state_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      total_d  = (sum > SUM_W'({TOT_W{1'b1}})) ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
    end else if (push_req) begin
      overflow_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      CAPTURE: if (test_ending || test_has_ended) state_d = DRAIN;
      DRAIN:   if (test_has_ended && (level_d == '0)) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
      done_q     <= (state_d == DONE);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= dct_buffer;
  end

endmodule

// File: tb/tb_nios_system_nios2_gen2_0_cpu_oci_trace_monitor.sv
// Bench for the trace monitor: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model; a TOT_W=4 copy checks saturation.
module tb_nios_system_nios2_gen2_0_cpu_oci_trace_monitor;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n, dct_valid, test_ending, test_has_ended, rd_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  logic [29:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, ovf_a, ovf_b, done_a, done_b;
  logic [4:0]  lvl_a, lvl_b;
  logic [31:0] tot_a;
  logic [3:0]  tot_b;

  always #5 clk = ~clk;

  nios_system_nios2_gen2_0_cpu_oci_trace_monitor u_a (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready), .fifo_level(lvl_a),
    .overflow(ovf_a), .total_count(tot_a), .drain_done(done_a));

  nios_system_nios2_gen2_0_cpu_oci_trace_monitor #(.TOT_W(4)) u_b (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready), .fifo_level(lvl_b),
    .overflow(ovf_b), .total_count(tot_b), .drain_done(done_b));

  // Reference model: contents as a queue, capture/finished as plain flags.
  logic [29:0]     mq[$];
  bit              m_cap = 1'b1, m_fin = 1'b0, m_ovf = 1'b0;
  longint unsigned m_tot_a = 0, m_tot_b = 0;
  int              passed = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("rd_valid", 64'(rd_valid_a), 64'(mq.size() != 0));
    chk("fifo_level", 64'(lvl_a), 64'(mq.size()));
    chk("overflow", 64'(ovf_a), 64'(m_ovf));
    chk("total_count", 64'(tot_a), m_tot_a);
    chk("total_count_w4", 64'(tot_b), m_tot_b);
    chk("drain_done", 64'(done_a), 64'(m_fin));
    if (mq.size() != 0) chk("rd_data", 64'(rd_data_a), 64'(mq[0]));
  endtask

  task automatic step(input bit rst, input bit v, input logic [29:0] d, input logic [3:0] c,
                      input bit te, input bit th, input bit rr);
    int n;
    bit pop, want;
    reset_n = !rst; dct_valid = v; dct_buffer = d; dct_count = c;
    test_ending = te; test_has_ended = th; rd_ready = rr;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_cap = 1'b1; m_fin = 1'b0; m_ovf = 1'b0; m_tot_a = 0; m_tot_b = 0;
    end else begin
      n    = mq.size();
      pop  = (n != 0) && rr;
      want = m_cap && v && (c != 0);
      if (pop) void'(mq.pop_front());
      if (want) begin
        if (n < DEPTH || pop) begin
          mq.push_back(d);
          m_tot_a = (m_tot_a + c > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tot_a + c;
          m_tot_b = (m_tot_b + c > 15) ? 15 : m_tot_b + c;
        end else m_ovf = 1'b1;
      end
      if (m_cap) begin
        if (te || th) m_cap = 1'b0;
      end else if (!m_fin && th && mq.size() == 0) m_fin = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 30'h5, 4'd3, 0, 0, 1);
    chk("reset_level", 64'(lvl_a), 64'd0);

    // Basic capture, 1-cycle visibility
    step(0, 1, 30'h1, 4'd3, 0, 0, 0);
    chk("first_head", 64'(rd_data_a), 64'h1);
    step(0, 1, 30'h2, 4'd5, 0, 0, 0);
    chk("basic_level", 64'(lvl_a), 64'd2);
    chk("basic_total", 64'(tot_a), 64'd8);

    // Zero-count frames are ignored
    step(0, 1, 30'h3, 4'd0, 0, 0, 0);
    chk("zero_cnt_level", 64'(lvl_a), 64'd2);
    chk("zero_cnt_total", 64'(tot_a), 64'd8);

    // Overflow: 17 frames into 16 entries
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 30'(100 + i), 4'd1, 0, 0, 0);
    chk("ovf_level", 64'(lvl_a), 64'd16);
    chk("ovf_flag", 64'(ovf_a), 64'd1);
    chk("ovf_total", 64'(tot_a), 64'd16);
    chk("ovf_total_w4", 64'(tot_b), 64'd15);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("ovf_drained", 64'(rd_valid_a), 64'd0);

    // Full FIFO with simultaneous push and pop
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 30'(200 + i), 4'd2, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 30'(300 + i), 4'd2, 0, 0, 1);
    chk("full_pp_level", 64'(lvl_a), 64'd16);
    chk("full_pp_ovf", 64'(ovf_a), 64'd0);
    chk("full_pp_head", 64'(rd_data_a), 64'd204);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 1);

    // End of test: drain three frames then done
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 30'(400 + i), 4'd1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("drain_order", 64'(rd_data_a), 64'(400 + i));
      step(0, 0, 0, 0, 0, 1, 1);
    end
    chk("drain_done_set", 64'(done_a), 64'd1);
    step(0, 1, 30'h7, 4'd5, 0, 0, 1);
    chk("done_ignores_frames", 64'(lvl_a), 64'd0);

    // Saturation and reset during drain
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 30'h11, 4'd15, 0, 0, 0);
    step(0, 1, 30'h12, 4'd15, 0, 0, 0);
    chk("sat_total_w4", 64'(tot_b), 64'd15);
    chk("sat_total_w32", 64'(tot_a), 64'd30);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 30'h13, 4'd2, 0, 1, 1);
    chk("mid_drain_rst_level", 64'(lvl_a), 64'd0);
    chk("mid_drain_rst_total", 64'(tot_b), 64'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, 30'($urandom),
           4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
